// File: rtl/sram_rw_port_ctrl_if.sv
// +---------------------------------------------------------------------------+
// | sram_rw_port_ctrl_if                                                      |
// | Request/response stream plus RW0_* macro port bundle for the controller.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W / 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata,
    output sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask,
    input  sram_rdata
  );

  modport mem (
    input  sram_en, sram_wmode, sram_addr, sram_wdata, sram_wmask,
    output sram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_rw_port_ctrl.sv
// +---------------------------------------------------------------------------+
// | sram_rw_port_ctrl                                                         |
// | Valid/ready front-end for a 1-cycle-latency RW SRAM with a credit-        |
// | protected response FIFO. Define SRAM_RDATA_REG_EN to register rdata.      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sram_rw_port_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 64,
  parameter int MASK_W     = DATA_W / 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic                 RW0_clk,
  input  logic                 reset_n,
  sram_rw_port_ctrl_if.slave   bus,
  output logic                 busy
);

  localparam int c_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RESP_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(RESP_DEPTH - 1);

  logic              w_accept;
  logic              w_acc_rd;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_push_data;
  logic [ADDR_W-1:0] w_addr;
  logic [MASK_W-1:0] w_wmask;
  logic [c_CNT_W-1:0] w_count_nxt;

  logic              r_req_ready;
  logic              r_rd_v1;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_occ;
  logic [c_CNT_W-1:0] r_count;
  logic [DATA_W-1:0] r_mem [RESP_DEPTH];

  assign w_accept = bus.req_valid && r_req_ready;
  assign w_acc_rd = w_accept && !bus.req_write;
  assign w_pop    = (r_occ != '0) && bus.resp_ready;
  assign w_addr   = bus.req_addr;
  assign w_wmask  = bus.req_wmask;

  assign bus.sram_en    = w_accept;
  assign bus.sram_wmode = w_accept && bus.req_write;
  assign bus.sram_addr  = w_addr;
  assign bus.sram_wdata = bus.req_wdata;
  assign bus.sram_wmask = w_wmask;

  always_ff @(posedge RW0_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_v1 <= 1'b0;
    end else begin
      r_rd_v1 <= w_acc_rd;
    end
  end

`ifdef SRAM_RDATA_REG_EN
  logic              r_rd_v2;
  logic [DATA_W-1:0] r_rd_data2;

  // Capture still happens at T+1 so a following write cannot disturb it.
  always_ff @(posedge RW0_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_v2 <= 1'b0;
    end else begin
      r_rd_v2 <= r_rd_v1;
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (r_rd_v1) begin
      r_rd_data2 <= bus.sram_rdata;
    end
  end

  assign w_push      = r_rd_v2;
  assign w_push_data = r_rd_data2;
`else
  assign w_push      = r_rd_v1;
  assign w_push_data = bus.sram_rdata;
`endif

  always_ff @(posedge RW0_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge RW0_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - c_CNT_W'(1);
      end
    end
  end

  // Credits cover FIFO entries plus reads still in the capture pipeline.
  assign w_count_nxt = r_count + c_CNT_W'(w_acc_rd) - c_CNT_W'(w_pop);

  always_ff @(posedge RW0_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt < c_DEPTH);
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = (r_occ != '0);
  assign bus.resp_rdata = r_mem[r_rd_ptr];
  assign busy           = (r_count != '0);

  a_no_overflow: assert property (@(posedge RW0_clk) disable iff (!reset_n)
    !(w_push && (r_occ == c_DEPTH)));

endmodule

`default_nettype wire

// File: tb/tb_sram_rw_port_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_sram_rw_port_ctrl                                                      |
// | Directed and random bench for sram_rw_port_ctrl with a macro model.       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_sram_rw_port_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int DEPTH  = 4;
`ifdef SRAM_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic RW0_clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_resp = 0;
  int   n_acc  = 0;
  int   acc_cyc = 0;

  sram_rw_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  sram_rw_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(DEPTH)
  ) dut (
    .RW0_clk(RW0_clk),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 RW0_clk = ~RW0_clk;
  always @(posedge RW0_clk) cyc <= cyc + 1;

  // Behavioural single-port macro, 1-cycle read latency, byte-masked writes.
  logic [DATA_W-1:0] sram_mem [1<<ADDR_W];
  logic [DATA_W-1:0] sram_q;
  always @(posedge RW0_clk) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) begin
        for (int b = 0; b < MASK_W; b++)
          if (bus.sram_wmask[b]) sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end else begin
        sram_q <= sram_mem[bus.sram_addr];
      end
    end
  end
  assign bus.sram_rdata = sram_q;

  // Reference: memory image plus in-order queue of expected read results.
  logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] got_q [$];
  logic [DATA_W-1:0] mon_exp;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(negedge RW0_clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        n_acc++;
        acc_cyc = cyc;
        if (bus.req_write)
          ref_mem[bus.req_addr] = merge(ref_mem[bus.req_addr], bus.req_wdata, bus.req_wmask);
        else
          exp_q.push_back(ref_mem[bus.req_addr]);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        mon_exp = (exp_q.size() > 0) ? exp_q[0] : 'x;
        total++;
        n_resp++;
        got_q.push_back(bus.resp_rdata);
        assert (exp_q.size() > 0 && bus.resp_rdata === mon_exp) else begin
          bad++;
          $error("FAIL resp_data got=%h exp=%h", bus.resp_rdata, mon_exp);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge RW0_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [8:0] a, input logic [63:0] d,
                      input logic [7:0] m);
    logic ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus.resp_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cycles, r0, first;
    logic ok, acc;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b1;

    // Reset state, with a request offered to prove nothing leaks to the macro
    #12;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_sram_en", 64'(bus.sram_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    bus.req_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    #2;
    check("rel_ready_pre", 64'(bus.req_ready), 64'd0);
    tick();
    check("rel_ready_post", 64'(bus.req_ready), 64'd1);

    // Write then read back, with accept-to-response latency
    send(1'b1, 9'h1A5, 64'h0123456789ABCDEF, 8'hFF);
    send(1'b0, 9'h1A5, 64'h0, 8'h0);
    first = 0;
    for (int i = 0; i < 20 && !bus.resp_valid; i++) tick();
    first = cyc;
    check("lat_cycles", 64'(first - acc_cyc), 64'(LAT));
    wait_idle();
    check("lat_data", got_q[got_q.size()-1], 64'h0123456789ABCDEF);

    // Byte mask
    send(1'b1, 9'h010, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    send(1'b1, 9'h010, 64'h0, 8'h0F);
    send(1'b0, 9'h010, 64'h0, 8'h0);
    wait_idle();
    check("mask_data", got_q[got_q.size()-1], 64'hFFFFFFFF00000000);

    // Read, write same address next cycle, read again
    send(1'b1, 9'h020, {8{8'hAA}}, 8'hFF);
    send(1'b0, 9'h020, 64'h0, 8'h0);
    send(1'b1, 9'h020, {8{8'h55}}, 8'hFF);
    send(1'b0, 9'h020, 64'h0, 8'h0);
    wait_idle();
    check("raw_first", got_q[got_q.size()-2], {8{8'hAA}});
    check("raw_second", got_q[got_q.size()-1], {8{8'h55}});

    for (int i = 0; i < 16; i++) send(1'b1, 9'h100 + 9'(i), {$urandom, $urandom}, 8'hFF);

    // Consumer stalled: only DEPTH reads may be accepted
    bus.resp_ready = 1'b0;
    r0 = n_resp;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (idx < 6);
      bus.req_write = 1'b0;
      bus.req_addr  = 9'h100 + 9'(idx);
      ok = bus.req_ready && bus.req_valid;
      tick();
      if (ok) idx++;
    end
    check("stall_accepts", 64'(idx), 64'(DEPTH));
    check("stall_ready_low", 64'(bus.req_ready), 64'd0);
    check("stall_no_resp", 64'(n_resp - r0), 64'd0);
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 9'h100 + 9'(idx);
      ok = bus.req_ready;
      tick();
      if (ok) idx++;
    end
    bus.req_valid = 1'b0;
    wait_idle();
    check("stall_resp_count", 64'(n_resp - r0), 64'd6);

    // Full throughput with consumer always ready
    r0 = n_resp;
    idx = 0;
    cycles = 0;
    while (idx < 16 && cycles < 100) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 9'h100 + 9'(idx % 16);
      ok = bus.req_ready;
      tick();
      cycles++;
      if (ok) idx++;
    end
    bus.req_valid = 1'b0;
    check("tput_cycles", 64'(cycles), 64'd16);
    for (int i = 0; i < LAT - 1; i++) tick();
    check("tput_resp_15", 64'(n_resp - r0), 64'd15);
    check("tput_last_valid", 64'(bus.resp_valid), 64'd1);
    tick();
    check("tput_resp_16", 64'(n_resp - r0), 64'd16);
    check("tput_drained", 64'(bus.resp_valid), 64'd0);

    // Reset while a read is in flight
    send(1'b0, 9'h101, 64'h0, 8'h0);
    r0 = n_resp;
    reset_n = 1'b0;
    #2;
    check("flt_busy_rst", 64'(busy), 64'd0);
    check("flt_ready_rst", 64'(bus.req_ready), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("flt_ready_rel", 64'(bus.req_ready), 64'd1);
    check("flt_busy_rel", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("flt_no_resp", 64'(n_resp - r0), 64'd0);

    // Random mix over pre-written addresses with a random consumer
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (acc) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = 9'h100 + 9'($urandom_range(0, 7));
        bus.req_wdata = {$urandom, $urandom};
        bus.req_wmask = 8'($urandom);
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      acc = bus.req_valid ? bus.req_ready : 1'b1;
      tick();
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    wait_idle();
    check("rand_pending", 64'(exp_q.size()), 64'd0);
    check("rand_busy", 64'(busy), 64'd0);
    check("rand_ready", 64'(bus.req_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
